// File: rtl/enc_event_pkg.sv
// rtl/enc_event_pkg.sv - shared types and helpers for the encoder event queue
// Holds the default code width, the queue entry layout and the occupancy
// counter width helper. Optional macro: ENC_EVT_TIMESTAMP_EN adds a
// timestamp field to the entry layout.
package enc_event_pkg;

  localparam int ENC_CODE_W = 2;
  localparam int ENC_TS_W   = 16;

  // Entry layout at default widths; the top packs entries as {ts, code}
  // in this same order so the two stay interchangeable.
  typedef struct packed {
`ifdef ENC_EVT_TIMESTAMP_EN
    logic [ENC_TS_W-1:0]   ts;
`endif
    logic [ENC_CODE_W-1:0] code;
  } enc_entry_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/enc_event_fifo.sv
// rtl/enc_event_fifo.sv - generic first-word-fall-through FIFO storage
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write request and data (accepted when not full or popping)
//   pop             read request (ignored while empty)
//   rdata           head entry, reads 0 while empty
//   full, empty     registered status
//   count           registered occupancy
module enc_event_fifo
  import enc_event_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    cnt_next;

  // A push into a full FIFO is legal only when the head leaves this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    cnt_next = count;
    if (do_push && !do_pop) begin
      cnt_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_next;
      full  <= (cnt_next == CW'(DEPTH));
      empty <= (cnt_next == '0);
    end
  end

  // Storage needs no reset: stale contents are hidden behind empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/enc_event_queue.sv
// rtl/enc_event_queue.sv - event detector and queue behind the priority encoder
// Optional macro: ENC_EVT_TIMESTAMP_EN adds TS_W, a free-running cycle
// counter and the evt_ts output.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   enc_code, enc_valid  encoder output sampled every cycle
//   evt_code, evt_valid  head of queue (FWFT), valid while non-empty
//   evt_ready            consumer takes the head this cycle
//   full, empty, count   registered queue status
//   ovf_clr              clears the sticky overflow flag
//   overflow, drop_cnt   sticky drop flag, saturating drop counter
//   evt_ts               (macro only) timestamp aligned with evt_code
module enc_event_queue
  import enc_event_pkg::*;
#(
  parameter int CODE_W = ENC_CODE_W,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
`ifdef ENC_EVT_TIMESTAMP_EN
  , parameter int TS_W = ENC_TS_W
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CODE_W-1:0]         enc_code,
  input  logic                      enc_valid,
  output logic [CODE_W-1:0]         evt_code,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic                      full,
  output logic                      empty,
  output logic [count_w(DEPTH)-1:0] count,
  input  logic                      ovf_clr,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt
`ifdef ENC_EVT_TIMESTAMP_EN
  , output logic [TS_W-1:0]         evt_ts
`endif
);

`ifdef ENC_EVT_TIMESTAMP_EN
  localparam int EW = TS_W + CODE_W;
`else
  localparam int EW = CODE_W;
`endif

  logic              prev_valid;
  logic [CODE_W-1:0] prev_code;
  logic              evt;
  logic              pop;
  logic              push;
  logic              drop;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;

  // A new event is a valid rising edge or a code change while valid.
  assign evt  = enc_valid & (~prev_valid | (enc_code != prev_code));
  assign pop  = evt_valid & evt_ready;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_code  <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      prev_valid <= enc_valid;
      prev_code  <= enc_code;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

`ifdef ENC_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  assign wr_entry           = {ts_cnt, enc_code};
  assign {evt_ts, evt_code} = rd_entry;
`else
  assign wr_entry = enc_code;
  assign evt_code = rd_entry;
`endif

  assign evt_valid = ~empty;

  enc_event_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_enc_event_queue.sv
// tb/tb_enc_event_queue.sv - scoreboard bench for enc_event_queue
module tb_enc_event_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    enc_code;
  logic          enc_valid;
  logic [1:0]    evt_code;
  logic          evt_valid;
  logic          evt_ready;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf_clr;
  logic          overflow;
  logic [7:0]    drop_cnt;
`ifdef ENC_EVT_TIMESTAMP_EN
  logic [15:0]   evt_ts;
`endif

  enc_event_queue dut (
    .clk       (clk),
    .rst       (rst),
    .enc_code  (enc_code),
    .enc_valid (enc_valid),
    .evt_code  (evt_code),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
`ifdef ENC_EVT_TIMESTAMP_EN
    , .evt_ts  (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  code;
    logic [15:0] ts;
  } exp_t;

  // Reference model: queue contents as a list of accepted events,
  // occupancy, sticky overflow and dropped-event count.
  exp_t        exp_q[$];
  int          m_cnt;
  bit          m_ovf;
  int          m_drop;
  bit          m_pv;
  logic [1:0]  m_pc;
  logic [15:0] m_time;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ovf  = 0;
      m_drop = 0;
      m_pv   = 0;
      m_pc   = 2'b00;
      m_time = 16'd0;
    end else begin
      bit   ev, pp, ps;
      exp_t e;
      ev = enc_valid && (!m_pv || enc_code != m_pc);
      pp = (m_cnt > 0) && evt_ready;
      ps = ev && (m_cnt < DEPTH || pp);
      if (ps) begin
        e.code = enc_code;
        e.ts   = m_time;
        exp_q.push_back(e);
      end
      m_cnt = m_cnt + (ps ? 1 : 0) - (pp ? 1 : 0);
      if (ev && !ps) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else if (ovf_clr) begin
        m_ovf = 0;
      end
      m_pv   = enc_valid;
      m_pc   = enc_code;
      m_time = m_time + 16'd1;
    end
  end

  // Monitor: compare status every cycle and retire the head on handshake.
  always @(negedge clk) begin
    chk("evt_valid", evt_valid, m_cnt > 0);
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (evt_valid) begin
      if (exp_q.size() == 0) begin
        chk("head_present", 0, 1);
      end else begin
        chk("evt_code", evt_code, exp_q[0].code);
`ifdef ENC_EVT_TIMESTAMP_EN
        chk("evt_ts", evt_ts, exp_q[0].ts);
`endif
        if (evt_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("evt_code_empty", evt_code, 0);
    end
  end

  task automatic drive(input bit v, input logic [1:0] c, input bit r, input bit clr);
    @(posedge clk);
    #1;
    enc_valid = v;
    enc_code  = c;
    evt_ready = r;
    ovf_clr   = clr;
  endtask

  initial begin
    rst       = 1'b1;
    enc_valid = 1'b0;
    enc_code  = 2'b00;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle
    repeat (10) drive(0, 2'b00, 0, 0);
    // steady valid with one code -> one entry
    repeat (5) drive(1, 2'b10, 0, 0);
    repeat (2) drive(0, 2'b00, 1, 0);
    // fill with four codes
    for (int c = 0; c < 4; c++) begin
      repeat (2) drive(1, 2'(c), 0, 0);
    end
    // three drops while full
    drive(1, 2'b10, 0, 0);
    drive(1, 2'b01, 0, 0);
    drive(1, 2'b00, 0, 0);
    // clear overflow with no drop
    drive(1, 2'b00, 0, 1);
    drive(1, 2'b00, 0, 0);
    // push and pop together while full
    drive(1, 2'b01, 1, 0);
    repeat (6) drive(0, 2'b00, 1, 0);
    // drain then fill three and reset between edges
    drive(1, 2'b01, 0, 0);
    drive(1, 2'b10, 0, 0);
    drive(1, 2'b11, 0, 0);
    drive(0, 2'b00, 0, 0);
    drive(0, 2'b00, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_evt_code", evt_code, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : enc_code;
      drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0);
    end
    repeat (8) drive(0, 2'b00, 1, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_event_queue.md
Name: enc_event_queue

Overview:
Sits directly downstream of the 4-to-2 priority encoder. Samples the encoder's 2-bit code and valid flag each clock and detects new events: valid rising, or code changing while valid. Queues each event's code in a small first-word-fall-through FIFO. Presents queued events to the consumer over a valid/ready handshake, with full/empty/count status and overflow tracking.

Parameters:
CODE_W, 2, width of encoder code (matches encoder out width)
DEPTH, 4, FIFO entries; power of two, >= 2
DROP_W, 8, width of saturating dropped-event counter

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-high reset
enc_code  in  CODE_W  code from encoder out
enc_valid  in  1  encoder valid flag
evt_code  out  CODE_W  head-of-queue code (FWFT)
evt_valid  out  1  queue non-empty
evt_ready  in  1  consumer accepts head this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  clog2(DEPTH+1)  occupancy
ovf_clr  in  1  clears sticky overflow
overflow  out  1  sticky: an event was dropped
drop_cnt  out  DROP_W  dropped events, saturating

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset (async assert, sync release): FIFO empty, rd/wr pointers 0, count 0, evt_valid 0, empty 1, full 0, overflow 0, drop_cnt 0, prev_valid 0, prev_code 0. evt_code reads as 0 while empty after reset.
- Input sampling: prev_valid/prev_code register enc_valid/enc_code every cycle.
- Event: evt = enc_valid & (!prev_valid | enc_code != prev_code).
  - Steady valid with an unchanged code produces exactly one event.
  - enc_valid low produces no event; enc_code is ignored.
- Push: evt & (!full | pop). Written at wr_ptr; the entry is visible on evt_code the next cycle. Latency from input edge to evt_valid = 1 cycle.
- Pop: evt_valid & evt_ready. rd_ptr advances; the next entry (if any) appears the same cycle after the edge.
- Simultaneous push+pop: count unchanged.
  - Allowed when full: the entry is accepted, not dropped.
  - When empty, a pop is impossible (evt_valid=0), so only the push occurs.
- Drop: evt & full & !pop. Entry is discarded, FIFO is unchanged, overflow←1, and drop_cnt increments, saturating at all-ones.
- Overflow clear: ovf_clr clears overflow next cycle. If a drop occurs the same cycle, set wins (overflow stays 1). drop_cnt is cleared only by rst.
- Pointers: log2(DEPTH) bits, wrap naturally. full/empty/count are derived from a registered count; all are registered outputs, with no combinational input→output paths except evt_valid/evt_code from state.
- evt_ready while empty: ignored.
- Reset mid-operation: all queued entries are lost immediately; no partial state survives.

Optional Feature:
ENC_EVT_TIMESTAMP_EN
- Defined: parameter TS_W (default 16) and a free-running TS_W-bit cycle counter (reset 0, wraps). Each pushed entry stores {timestamp, code}, where timestamp is the counter value in the cycle evt was detected. Adds output evt_ts [TS_W-1:0], aligned with evt_code, reset 0.
- Undefined: no counter, no evt_ts port, FIFO width = CODE_W.

Decomposition:
- Package enc_event_pkg holds:
  - CODE_W default
  - the entry struct typedef (code, plus ts under the macro)
  - the count-width function clog2(DEPTH+1)
- One natural sub-module: enc_event_fifo, the generic FWFT storage with push/pop/full/empty/count.
- Edge detection, drop logic and overflow stay in the top-level.

Test Plan:
- Reset then idle: enc_valid=0 for 10 cycles → evt_valid=0, empty=1, count=0, overflow=0, drop_cnt=0.
- Edge/dedupe: enc_valid=1 and code=2'b10 held 5 cycles → exactly one entry; evt_code=2'b10 one cycle after the first valid, count=1.
- Code change: evt_ready=0; codes 00,01,10,11 each held 2 cycles with valid=1 → count=4, full=1. Pop with evt_ready=1 → order 00,01,10,11, then empty=1.
- Overflow: queue full, evt_ready=0, 3 more distinct codes → count stays 4, overflow=1, drop_cnt=3. Pulse ovf_clr with no drop → overflow=0, drop_cnt=3.
- Full push+pop: full with evt_ready=1 while a new code 01 arrives → count stays 4, drop_cnt unchanged, 01 is the last entry out.
- Async reset mid-stream: assert rst between clock edges with count=3 → outputs return to reset values immediately, without waiting for a clock edge. With ENC_EVT_TIMESTAMP_EN, events at cycles 5 and 9 → evt_ts=5 then 9.
